// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// FSM states and the default datapath width.
package hilo_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Codes 6 and 7 are undefined and ignored by the unit.
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of an unsigned shift-add multiply or restoring divide on
// the upper half of the shared HI:LO accumulator.
module muldiv_step
  import hilo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] part,
  input  logic             lo_lsb,
  input  logic             lo_msb,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] part_next,
  output logic             q_bit
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum       = {1'b0, part} + (lo_lsb ? {1'b0, opnd} : '0);
    shifted   = {part, lo_msb};
    diff      = shifted - {1'b0, opnd};
    part_next = '0;
    q_bit     = 1'b0;
    if (is_div) begin
      // Remainder stays below the divisor, so diff[WIDTH] is a true borrow.
      q_bit     = ~diff[WIDTH];
      part_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    end else begin
      // q_bit carries the product bit that shifts down into LO.
      part_next = sum[WIDTH:1];
      q_bit     = sum[0];
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO.
//   state     | meaning
//   ST_IDLE   | waiting for Start; MTHI/MTLO load directly
//   ST_CALC   | one mult/div step per cycle, cnt 0..WIDTH-1
//   ST_FINISH | sign fix, load Hi/Lo, pulse Done
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   a_q;
  logic               is_div_q;
  logic               neg_res;
  logic               neg_rem;
  logic               div_zero;

  logic             sgn, a_neg, b_neg, is_div_in;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_comb begin
    sgn       = (Op == OP_MULT) || (Op == OP_DIV);
    is_div_in = (Op == OP_DIV) || (Op == OP_DIVU);
    a_neg     = sgn & A[WIDTH-1];
    b_neg     = sgn & B[WIDTH-1];
    mag_a     = a_neg ? -A : A;
    mag_b     = b_neg ? -B : B;
  end

  logic [WIDTH-1:0] part_next;
  logic             q_bit;
  logic [WIDTH-1:0] lower_next;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div    (is_div_q),
    .part      (acc[2*WIDTH-1:WIDTH]),
    .lo_lsb    (acc[0]),
    .lo_msb    (acc[WIDTH-1]),
    .opnd      (opnd),
    .part_next (part_next),
    .q_bit     (q_bit)
  );

  assign lower_next = is_div_q ? {acc[WIDTH-2:0], q_bit} : {q_bit, acc[WIDTH-1:1]};

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem, hi_res, lo_res;

  always_comb begin
    prod   = neg_res ? -acc : acc;
    quot   = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem    = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    hi_res = prod[2*WIDTH-1:WIDTH];
    lo_res = prod[WIDTH-1:0];
    if (is_div_q) begin
      hi_res = div_zero ? a_q : rem;
      lo_res = div_zero ? '1 : quot;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      a_q      <= '0;
      is_div_q <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Hi       <= '0;
      Lo       <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start) begin
            if (is_muldiv(Op)) begin
              acc      <= {{WIDTH{1'b0}}, (is_div_in ? mag_a : mag_b)};
              opnd     <= is_div_in ? mag_b : mag_a;
              a_q      <= A;
              is_div_q <= is_div_in;
              neg_res  <= a_neg ^ b_neg;
              neg_rem  <= a_neg;
              div_zero <= (B == '0);
              cnt      <= '0;
              Busy     <= 1'b1;
              state    <= ST_CALC;
            end else if (Op == OP_MTHI) begin
              Hi <= A;
            end else if (Op == OP_MTLO) begin
              Lo <= A;
            end
          end
        end
        ST_CALC: begin
          acc <= {part_next, lower_next};
          if (cnt == CW'(WIDTH - 1)) begin
            state <= ST_FINISH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_FINISH: begin
          Hi    <= hi_res;
          Lo    <= lo_res;
          Done  <= 1'b1;
          Busy  <= 1'b0;
          cnt   <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: mult/div results, latency, MTHI/MTLO,
// ignored starts and mid-operation reset.
module tb_hilo_muldiv_unit;
  import hilo_pkg::*;

  logic        Clk, Rst, Start, Busy, Done;
  logic [2:0]  Op;
  logic [31:0] A, B, Hi, Lo;

  int n_cmp = 0;
  int n_bad = 0;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Issues one op at a negedge; edges counts the Start edge as 1 and stops
  // at the first negedge where Done is seen (or at a 100-edge bound).
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int edges, output logic busy_first, output logic busy_at_done,
                       output logic [31:0] hi_before, output logic [31:0] lo_before);
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge Clk);
    Start = 1'b0;
    edges = 1;
    busy_first = Busy;
    hi_before = Hi; lo_before = Lo;
    while (!Done && edges < 100) begin
      hi_before = Hi; lo_before = Lo;
      @(negedge Clk);
      edges++;
    end
    busy_at_done = Busy;
  endtask

  task automatic test_reset();
    Rst = 1'b1; Start = 1'b0; Op = 3'd0; A = '0; B = '0;
    #12;
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", Busy); end
    n_cmp++; if (Done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", Done); end
    n_cmp++; if (Hi !== 32'h0) begin n_bad++; $display("FAIL reset_hi: got %h want 0", Hi); end
    n_cmp++; if (Lo !== 32'h0) begin n_bad++; $display("FAIL reset_lo: got %h want 0", Lo); end
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  task automatic test_multu();
    int e; logic bf, bd; logic [31:0] hb, lb;
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, e, bf, bd, hb, lb);
    n_cmp++; if (e !== 34) begin n_bad++; $display("FAIL multu_latency: got %0d want 34", e); end
    n_cmp++; if (bf !== 1'b1) begin n_bad++; $display("FAIL multu_busy: got %b want 1", bf); end
    n_cmp++; if (bd !== 1'b0) begin n_bad++; $display("FAIL multu_busy_at_done: got %b want 0", bd); end
    n_cmp++; if (hb !== 32'h0 || lb !== 32'h0) begin n_bad++; $display("FAIL multu_hold: got %h/%h want 0/0", hb, lb); end
    n_cmp++; if (Hi !== 32'h1) begin n_bad++; $display("FAIL multu_hi: got %h want 00000001", Hi); end
    n_cmp++; if (Lo !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL multu_lo: got %h want fffffffe", Lo); end
    @(negedge Clk);
    n_cmp++; if (Done !== 1'b0) begin n_bad++; $display("FAIL done_pulse_width: got %b want 0", Done); end
  endtask

  task automatic test_mult();
    int e; logic bf, bd; logic [31:0] hb, lb;
    do_op(OP_MULT, -32'sd3, 32'd7, e, bf, bd, hb, lb);
    n_cmp++; if (hb !== 32'h1 || lb !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL mult_hold: got %h/%h want 00000001/fffffffe", hb, lb); end
    n_cmp++; if (Hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_hi: got %h want ffffffff", Hi); end
    n_cmp++; if (Lo !== 32'hFFFF_FFEB) begin n_bad++; $display("FAIL mult_lo: got %h want ffffffeb", Lo); end
    do_op(OP_MULT, -32'sd5, -32'sd6, e, bf, bd, hb, lb);
    n_cmp++; if (Hi !== 32'h0 || Lo !== 32'd30) begin n_bad++; $display("FAIL mult_negneg: got %h/%h want 0/1e", Hi, Lo); end
  endtask

  task automatic test_div();
    int e; logic bf, bd; logic [31:0] hb, lb;
    do_op(OP_DIV, -32'sd7, 32'd2, e, bf, bd, hb, lb);
    n_cmp++; if (Lo !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_lo: got %h want fffffffd", Lo); end
    n_cmp++; if (Hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_hi: got %h want ffffffff", Hi); end
    do_op(OP_DIVU, 32'd100, 32'd0, e, bf, bd, hb, lb);
    n_cmp++; if (e !== 34) begin n_bad++; $display("FAIL divz_latency: got %0d want 34", e); end
    n_cmp++; if (Lo !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL divz_lo: got %h want ffffffff", Lo); end
    n_cmp++; if (Hi !== 32'd100) begin n_bad++; $display("FAIL divz_hi: got %h want 00000064", Hi); end
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, e, bf, bd, hb, lb);
    n_cmp++; if (Lo !== 32'h8000_0000 || Hi !== 32'h0) begin n_bad++; $display("FAIL div_minneg1: got %h/%h want 0/80000000", Hi, Lo); end
    do_op(OP_DIVU, 32'd100, 32'd7, e, bf, bd, hb, lb);
    n_cmp++; if (Lo !== 32'd14 || Hi !== 32'd2) begin n_bad++; $display("FAIL divu_100_7: got %h/%h want 2/e", Hi, Lo); end
    do_op(OP_DIV, 32'd7, -32'sd2, e, bf, bd, hb, lb);
    n_cmp++; if (Lo !== 32'hFFFF_FFFD || Hi !== 32'd1) begin n_bad++; $display("FAIL div_pos_neg: got %h/%h want 1/fffffffd", Hi, Lo); end
  endtask

  task automatic test_mthi_mtlo();
    logic seen;
    seen = 1'b0;
    @(negedge Clk);
    Start = 1'b1; Op = OP_MTHI; A = 32'h1234;
    @(negedge Clk);
    seen = seen | Busy | Done;
    n_cmp++; if (Hi !== 32'h1234) begin n_bad++; $display("FAIL mthi_hi: got %h want 00001234", Hi); end
    Op = OP_MTLO; A = 32'h5678;
    @(negedge Clk);
    Start = 1'b0;
    seen = seen | Busy | Done;
    n_cmp++; if (Lo !== 32'h5678) begin n_bad++; $display("FAIL mtlo_lo: got %h want 00005678", Lo); end
    n_cmp++; if (Hi !== 32'h1234) begin n_bad++; $display("FAIL mtlo_hi_kept: got %h want 00001234", Hi); end
    repeat (2) begin @(negedge Clk); seen = seen | Busy | Done; end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL mt_busy_done: got %b want 0", seen); end
  endtask

  task automatic test_undefined_op();
    logic seen;
    seen = 1'b0;
    @(negedge Clk);
    Start = 1'b1; Op = 3'd6; A = 32'hDEAD; B = 32'h3;
    @(negedge Clk);
    Op = 3'd7;
    @(negedge Clk);
    Start = 1'b0;
    repeat (3) begin @(negedge Clk); seen = seen | Busy | Done; end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL undef_busy: got %b want 0", seen); end
    n_cmp++; if (Hi !== 32'h1234 || Lo !== 32'h5678) begin n_bad++; $display("FAIL undef_hilo: got %h/%h want 1234/5678", Hi, Lo); end
  endtask

  task automatic test_back_to_back();
    int e; int dones;
    @(negedge Clk);
    Start = 1'b1; Op = OP_MULTU; A = 32'd5; B = 32'd6;
    @(negedge Clk);
    Start = 1'b0;
    e = 1;
    repeat (4) begin @(negedge Clk); e++; end
    Start = 1'b1; Op = OP_DIVU; A = 32'd100; B = 32'd7;
    @(negedge Clk); e++;
    Start = 1'b0;
    while (!Done && e < 100) begin @(negedge Clk); e++; end
    n_cmp++; if (e !== 34) begin n_bad++; $display("FAIL b2b_latency: got %0d want 34", e); end
    n_cmp++; if (Hi !== 32'h0 || Lo !== 32'd30) begin n_bad++; $display("FAIL b2b_result: got %h/%h want 0/1e", Hi, Lo); end
    dones = 0;
    repeat (40) begin @(negedge Clk); if (Done) dones++; end
    n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL b2b_extra_done: got %0d want 0", dones); end
  endtask

  task automatic test_reset_abort();
    int e; logic bf, bd; logic [31:0] hb, lb; logic seen;
    seen = 1'b0;
    @(negedge Clk);
    Start = 1'b1; Op = OP_DIVU; A = 32'd100; B = 32'd7;
    @(negedge Clk);
    Start = 1'b0;
    // counter reads k after Start edge + k edges
    repeat (10) begin @(negedge Clk); seen = seen | Done; end
    Rst = 1'b1;
    #1;
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", Busy); end
    n_cmp++; if (Hi !== 32'h0 || Lo !== 32'h0) begin n_bad++; $display("FAIL abort_hilo: got %h/%h want 0/0", Hi, Lo); end
    repeat (2) begin @(negedge Clk); seen = seen | Done; end
    Rst = 1'b0;
    repeat (30) begin @(negedge Clk); seen = seen | Done | Busy; end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_no_done: got %b want 0", seen); end
    do_op(OP_DIVU, 32'd9, 32'd3, e, bf, bd, hb, lb);
    n_cmp++; if (e !== 34) begin n_bad++; $display("FAIL post_reset_latency: got %0d want 34", e); end
    n_cmp++; if (Lo !== 32'd3 || Hi !== 32'd0) begin n_bad++; $display("FAIL post_reset_divu: got %h/%h want 0/3", Hi, Lo); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_undefined_op();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
